fft_stream_driver: RTL and testbench
====================================

Name: fft_stream_driver

Overview:
- Host-side counterpart of the FFT core's sequencing controller.
- Holds an N-word input frame loaded by the host and issues a one-cycle FFT_START pulse.
- Streams the frame serially into the core, waits for FFT_DONE, then captures N serial result words into a readable result buffer.
- Sits between the host/test logic and the FFT core's serial in/out pins.

Parameters:
- N, 16: samples per frame. Power of two, 2..64.
- DW, 16: sample and result word width.
- START_TO_DATA, 1: cycles from the FFT_START pulse cycle to the sample-0 cycle. Range 1..4.
- TIMEOUT_CYCLES, 64: maximum WAIT duration before the error path is taken (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- WR_EN  in  1  host write strobe for the input frame buffer.
- WR_ADDR  in  log2(N)  input buffer write address.
- WR_DATA  in  DW  input sample.
- GO  in  1  single-cycle request to run one frame.
- BUSY  out  1  high from GO acceptance until RESULT_VALID rises.
- RESULT_VALID  out  1  result buffer holds a complete frame.
- RD_ADDR  in  log2(N)  result buffer read address.
- RD_DATA  out  DW  combinational read of the result buffer.
- ERR  out  1  sticky timeout flag.
- FFT_START  out  1  start pulse to the FFT core.
- FFT_DIN  out  DW  serial sample to the core.
- FFT_DONE  in  1  core's first-result strobe.
- FFT_DOUT  in  DW  serial result from the core.

Behaviour:
- Async reset (RESET_N low):
  - State IDLE.
  - BUSY, RESULT_VALID, ERR, FFT_START = 0; FFT_DIN = 0.
  - Counters cleared; buffer contents undefined.
  - Reset mid-frame aborts the frame; FFT_START is never left high.
- WR_EN is accepted in any state. Writes during BUSY are ignored: the frame is frozen from GO acceptance.
- States:
  - IDLE: GO=1 -> PULSE, BUSY<=1, RESULT_VALID<=0. GO while BUSY is ignored.
  - PULSE: FFT_START=1 for exactly this one cycle; the cycle before it FFT_START is 0, which guarantees a rising edge for the core. Then LEAD.
  - LEAD: START_TO_DATA-1 cycles with FFT_DIN=0. When START_TO_DATA=1, LEAD is skipped.
  - FEED: N cycles. FFT_DIN = frame[k] in the k-th cycle (k=0..N-1), driven from a register (no combinational path from the buffer). Then WAIT; FFT_DIN returns to 0.
  - WAIT: idle until FFT_DONE=1. The FFT_DONE cycle itself captures FFT_DOUT as result[0] -> COLLECT (index 1).
  - COLLECT: captures result[i] = FFT_DOUT on each of the next N-1 cycles, unconditionally (FFT_DONE is a single pulse). After result[N-1] -> IDLE; BUSY<=0 and RESULT_VALID<=1 on the same edge.
- An FFT_DONE pulse outside WAIT is ignored.
- RESULT_VALID stays high until the next GO acceptance.
- Counter widths: log2(N)+1 bits; the index wraps only via the state change, never mid-state.
- Nominal run with the N=16 core: 1 + 16 + gap + 16 cycles; GO-to-RESULT_VALID latency is fixed for a fixed core.
- GO and WR_EN in the same IDLE cycle: the write lands first, so the frame includes it.

Optional Feature:
- Macro FFT_STREAM_DRIVER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYCLES cycles without FFT_DONE: ERR<=1 (sticky until reset or next GO), RESULT_VALID stays 0, BUSY<=0 -> IDLE.
- Undefined:
  - WAIT waits indefinitely.
  - ERR is tied to 0 and no counter logic exists.

Test Plan:
- Load frame[k]=k+1 (k=0..15), GO, behavioural core model with DONE 2 cycles after the last sample -> FFT_START high exactly 1 cycle; FFT_DIN = 1..16 on consecutive cycles; RESULT_VALID after the 16th result; RD_ADDR=i returns model output i.
- GO pulsed again while BUSY, and WR_EN to addr 3 with 0xBEEF mid-frame -> no second FFT_START; frame unchanged; next run still streams the original value at sample 3.
- START_TO_DATA=3 -> two zero cycles between FFT_START and sample 0.
- RESET_N low during FEED at sample 7 -> all outputs 0 immediately (async); after release a new GO runs a clean frame.
- Spurious FFT_DONE during FEED, then a real one in WAIT -> capture starts only at the WAIT pulse.
- TIMEOUT_EN defined, model never raises DONE, TIMEOUT_CYCLES=64 -> ERR=1 and BUSY=0 after 64 WAIT cycles, RESULT_VALID=0; next GO clears ERR.

Source files
------------

// File: rtl/fft_stream_driver.sv
// -----------------------------------------------------------------------------
// fft_stream_driver
//
// Host-side sequencer for a serial FFT core. The host fills an N-word input
// frame, pulses GO, and this block:
//   1. issues a single-cycle FFT_START pulse,
//   2. waits START_TO_DATA-1 lead cycles (FFT_DIN held at 0),
//   3. streams frame[0..N-1] on FFT_DIN, one word per cycle, from a register,
//   4. waits for the core's FFT_DONE strobe,
//   5. captures N result words from FFT_DOUT (the first on the DONE cycle),
//   6. raises RESULT_VALID and drops BUSY on the same edge.
//
// Optional feature (macro FFT_STREAM_DRIVER_TIMEOUT_EN):
//   When defined, WAIT is bounded to TIMEOUT_CYCLES cycles. On expiry the
//   frame is abandoned: ERR is set (sticky until reset or next accepted GO),
//   RESULT_VALID stays low and the FSM returns to IDLE.
//   When undefined, WAIT waits indefinitely and ERR is tied low.
//
// Ports:
//   CLK           clock, rising edge
//   RESET_N       asynchronous active-low reset
//   WR_EN/WR_ADDR/WR_DATA  input frame write port (ignored while BUSY)
//   GO            single-cycle run request (ignored while BUSY)
//   BUSY          high from GO acceptance until RESULT_VALID rises
//   RESULT_VALID  result buffer holds a complete frame
//   RD_ADDR/RD_DATA  combinational result buffer read port
//   ERR           sticky timeout flag
//   FFT_START     start pulse to the core
//   FFT_DIN       serial sample to the core
//   FFT_DONE      core's first-result strobe
//   FFT_DOUT      serial result from the core
//   dbg_state     current FSM state encoding (observation only)
//
// Handshake: there is no backpressure. A GO is accepted on any rising edge
// where GO=1 and the FSM is in IDLE; the core contract is purely positional
// (sample k appears START_TO_DATA+k cycles after the FFT_START cycle, and
// result i appears i cycles after the FFT_DONE cycle).
// -----------------------------------------------------------------------------
module fft_stream_driver #(
  parameter int N              = 16,
  parameter int DW             = 16,
  parameter int START_TO_DATA  = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 WR_EN,
  input  logic [$clog2(N)-1:0] WR_ADDR,
  input  logic [DW-1:0]        WR_DATA,
  input  logic                 GO,
  output logic                 BUSY,
  output logic                 RESULT_VALID,
  input  logic [$clog2(N)-1:0] RD_ADDR,
  output logic [DW-1:0]        RD_DATA,
  output logic                 ERR,
  output logic                 FFT_START,
  output logic [DW-1:0]        FFT_DIN,
  input  logic                 FFT_DONE,
  input  logic [DW-1:0]        FFT_DOUT,
  output logic [2:0]           dbg_state
);

  localparam int AW       = $clog2(N);
  localparam int CW       = AW + 1;
  localparam int LEAD_LEN = START_TO_DATA - 1;

  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] LEAD_LAST = CW'((LEAD_LEN > 0) ? (LEAD_LEN - 1) : 0);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PULSE   = 3'd1;
  localparam logic [2:0] S_LEAD    = 3'd2;
  localparam logic [2:0] S_FEED    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_COLLECT = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          busy_q;
  logic          rv_q;
  logic [DW-1:0] din_q;

  logic [DW-1:0] in_buf  [N];
  logic [DW-1:0] res_buf [N];

  logic [AW-1:0] feed_next_idx;
  logic          cap_en;
  logic [AW-1:0] cap_idx;
  logic          wait_timeout;

  // Sample index for the cycle after the current FEED cycle. Only used when
  // cnt < N-1, so the AW-bit wrap never matters.
  assign feed_next_idx = cnt[AW-1:0] + AW'(1);

  // The DONE cycle itself carries result[0]; COLLECT carries result[cnt].
  assign cap_en  = ((state == S_WAIT) && FFT_DONE) || (state == S_COLLECT);
  assign cap_idx = (state == S_COLLECT) ? cnt[AW-1:0] : '0;

  // ---------------------------------------------------------------------------
  // Frame and result storage (no reset: contents are undefined after reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    // Writes only land in IDLE, which freezes the frame from GO acceptance.
    // A write in the same cycle as GO still lands because state is IDLE.
    if (WR_EN && (state == S_IDLE)) begin
      in_buf[WR_ADDR] <= WR_DATA;
    end
    if (cap_en) begin
      res_buf[cap_idx] <= FFT_DOUT;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT timeout
  // ---------------------------------------------------------------------------
`ifdef FFT_STREAM_DRIVER_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] tcnt;
  logic            err_q;

  // tcnt counts completed WAIT cycles; the WAIT cycle with tcnt==TO_LAST is
  // the last one allowed, so exactly TIMEOUT_CYCLES WAIT cycles elapse.
  assign wait_timeout = (state == S_WAIT) && !FFT_DONE && (tcnt == TO_LAST);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == S_IDLE) && GO) begin
        err_q <= 1'b0;
      end else if (wait_timeout) begin
        err_q <= 1'b1;
      end
      if (state == S_WAIT) begin
        tcnt <= tcnt + TO_W'(1);
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign ERR = err_q;
`else
  assign wait_timeout = 1'b0;
  assign ERR          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      rv_q   <= 1'b0;
      din_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (GO) begin
            state  <= S_PULSE;
            busy_q <= 1'b1;
            rv_q   <= 1'b0;
            cnt    <= '0;
          end
        end

        S_PULSE: begin
          cnt <= '0;
          if (LEAD_LEN == 0) begin
            // Sample 0 must be on FFT_DIN in the very next cycle.
            state <= S_FEED;
            din_q <= in_buf[0];
          end else begin
            state <= S_LEAD;
          end
        end

        S_LEAD: begin
          if (cnt == LEAD_LAST) begin
            state <= S_FEED;
            cnt   <= '0;
            din_q <= in_buf[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_FEED: begin
          // din_q already holds frame[cnt]; preload the next sample.
          if (cnt == LAST_IDX) begin
            state <= S_WAIT;
            cnt   <= '0;
            din_q <= '0;
          end else begin
            cnt   <= cnt + CW'(1);
            din_q <= in_buf[feed_next_idx];
          end
        end

        S_WAIT: begin
          if (FFT_DONE) begin
            state <= S_COLLECT;
            cnt   <= CW'(1);
          end else if (wait_timeout) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end

        S_COLLECT: begin
          // FFT_DONE is a single pulse; results follow unconditionally.
          if (cnt == LAST_IDX) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            rv_q   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          din_q  <= '0;
        end
      endcase
    end
  end

  // FFT_START decodes directly from the state register: it is high only in
  // PULSE, PULSE is always entered from IDLE (so the previous cycle is low),
  // and an async reset forces IDLE, so the pulse can never be left high.
  assign FFT_START    = (state == S_PULSE);
  assign FFT_DIN      = din_q;
  assign BUSY         = busy_q;
  assign RESULT_VALID = rv_q;
  assign RD_DATA      = res_buf[RD_ADDR];
  assign dbg_state    = state;

endmodule

// File: tb/tb_fft_stream_driver.sv
`timescale 1ns/1ps
module tb_fft_stream_driver;

  localparam int N   = 16;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int STD = 1;
  localparam int NOMINAL_LAT = 35;  // 1 pulse + 16 samples + 2 gap + 16 results

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main DUT signals (START_TO_DATA = 1)
  logic          wr_en, go, busy, result_valid, err, fft_start, fft_done;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data, fft_din, fft_dout;
  logic [2:0]    dbg_state;

  // Second DUT signals (START_TO_DATA = 3)
  logic          wr_en3, go3, busy3, rv3, err3, start3, done3;
  logic [AW-1:0] rd_addr3;
  logic [DW-1:0] rd_data3, din3, dout3;
  logic [2:0]    dbg_state3;

  fft_stream_driver #(.N(N), .DW(DW), .START_TO_DATA(STD), .TIMEOUT_CYCLES(64)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .GO(go), .BUSY(busy), .RESULT_VALID(result_valid), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
    .ERR(err), .FFT_START(fft_start), .FFT_DIN(fft_din), .FFT_DONE(fft_done),
    .FFT_DOUT(fft_dout), .dbg_state(dbg_state)
  );

  fft_stream_driver #(.N(N), .DW(DW), .START_TO_DATA(3), .TIMEOUT_CYCLES(64)) u_dut3 (
    .CLK(clk), .RESET_N(rst_n), .WR_EN(wr_en3), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .GO(go3), .BUSY(busy3), .RESULT_VALID(rv3), .RD_ADDR(rd_addr3), .RD_DATA(rd_data3),
    .ERR(err3), .FFT_START(start3), .FFT_DIN(din3), .FFT_DONE(done3),
    .FFT_DOUT(dout3), .dbg_state(dbg_state3)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_din_q[$];
  logic [DW-1:0] exp_res_q[$];
  logic [DW-1:0] frame[N];
  int start_count = 0;
  bit spurious = 1'b0;
  bit no_done  = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural FFT core: records the streamed frame, raises DONE two cycles
  // after the last sample, then emits out[i] = in[N-1-i] ^ 0x5A5A.
  // ---------------------------------------------------------------------------
  initial begin : core_model
    int m_wait, m_k, m_gap, m_oi;
    bit m_feed, m_out;
    logic [DW-1:0] m_in[N];
    logic [DW-1:0] m_res[N];
    m_wait = 0; m_k = 0; m_gap = 0; m_oi = 0; m_feed = 0; m_out = 0;
    fft_done = 1'b0;
    fft_dout = '0;
    forever begin
      @(negedge clk);
      fft_done = 1'b0;
      fft_dout = '0;
      if (!rst_n) begin
        m_wait = 0; m_k = 0; m_gap = 0; m_oi = 0; m_feed = 0; m_out = 0;
      end else begin
        if (m_out) begin
          fft_dout = m_res[m_oi];
          m_oi++;
          if (m_oi == N) m_out = 0;
        end
        if (m_gap > 0) begin
          m_gap--;
          if (m_gap == 0 && !no_done) begin
            fft_done = 1'b1;
            fft_dout = m_res[0];
            m_out = 1;
            m_oi = 1;
          end
        end
        if (fft_start) m_wait = STD;
        else if (m_wait > 0) begin
          m_wait--;
          if (m_wait == 0) begin m_feed = 1; m_k = 0; end
        end
        if (m_feed) begin
          m_in[m_k] = fft_din;
          if (spurious && m_k == 5) begin
            fft_done = 1'b1;
            fft_dout = 16'hDEAD;
          end
          m_k++;
          if (m_k == N) begin
            m_feed = 0;
            m_gap = 2;
            for (int i = 0; i < N; i++) m_res[i] = m_in[N-1-i] ^ 16'h5A5A;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: FFT_START width and FFT_DIN stream against exp_din_q
  // ---------------------------------------------------------------------------
  initial begin : din_monitor
    int mw, mk;
    bit feeding, prev_start;
    logic [DW-1:0] e;
    mw = 0; mk = 0; feeding = 0; prev_start = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mw = 0; mk = 0; feeding = 0; prev_start = 0;
      end else begin
        if (fft_start) begin
          start_count++;
          check("start_pulse_width", {31'd0, prev_start}, 32'd0);
          mw = STD;
        end else if (mw > 0) begin
          mw--;
          if (mw == 0) begin feeding = 1; mk = 0; end
        end
        if (feeding) begin
          if (exp_din_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL din_unexpected: got 0x%0h with no sample expected", fft_din);
          end else begin
            e = exp_din_q.pop_front();
            check($sformatf("din[%0d]", mk), {16'd0, fft_din}, {16'd0, e});
          end
          mk++;
          if (mk == N) feeding = 0;
        end else begin
          check("din_idle_zero", {16'd0, fft_din}, 32'd0);
        end
        prev_start = fft_start;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: on RESULT_VALID rising, read back the buffer against exp_res_q
  // ---------------------------------------------------------------------------
  initial begin : res_monitor
    bit rv_prev;
    logic [DW-1:0] e;
    rv_prev = 0;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (result_valid && !rv_prev) begin
        check("busy_low_at_valid", {31'd0, busy}, 32'd0);
        for (int i = 0; i < N; i++) begin
          rd_addr = AW'(i);
          #0.2;
          if (exp_res_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL result_unexpected: got 0x%0h at addr %0d", rd_data, i);
          end else begin
            e = exp_res_q.pop_front();
            check($sformatf("result[%0d]", i), {16'd0, rd_data}, {16'd0, e});
          end
        end
      end
      rv_prev = result_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_frame(input logic [DW-1:0] base, input logic [DW-1:0] step);
    for (int k = 0; k < N; k++) begin
      frame[k] = base + DW'(k) * step;
      write_word(AW'(k), frame[k]);
    end
  endtask

  task automatic start_run(input bit with_res, input bit with_wr,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (with_wr) frame[wa] = wd;
    for (int k = 0; k < N; k++) exp_din_q.push_back(frame[k]);
    if (with_res) for (int i = 0; i < N; i++) exp_res_q.push_back(frame[N-1-i] ^ 16'h5A5A);
    go = 1'b1; wr_en = with_wr; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
    check("busy_after_go", {31'd0, busy}, 32'd1);
    check("rv_cleared_by_go", {31'd0, result_valid}, 32'd0);
    check("err_cleared_by_go", {31'd0, err}, 32'd0);
  endtask

  task automatic wait_result(input int exp_lat);
    int lat;
    lat = 1;
    while (!result_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!result_valid) begin
      n_vec++; n_err++;
      $display("FAIL result_timeout: RESULT_VALID still 0 after %0d cycles", lat);
    end else if (exp_lat > 0) begin
      check("go_to_valid_latency", lat, exp_lat);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed test sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int s0;
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    wr_en3 = 1'b0; go3 = 1'b0; done3 = 1'b0; dout3 = '0; rd_addr3 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result_valid", {31'd0, result_valid}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_fft_start", {31'd0, fft_start}, 32'd0);
    check("reset_fft_din", {16'd0, fft_din}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frame k+1
    load_frame(16'd1, 16'd1);
    start_run(1'b1, 1'b0, '0, '0);
    wait_result(NOMINAL_LAT);

    // GO and write while busy: no second start, frame unchanged
    s0 = start_count;
    start_run(1'b1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    go = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    @(negedge clk);
    go = 1'b0; wr_en = 1'b0;
    wait_result(0);
    check("single_start_while_busy", start_count - s0, 32'd1);
    start_run(1'b1, 1'b0, '0, '0);   // sample 3 still expected as 4
    wait_result(NOMINAL_LAT);

    // GO and WR_EN in the same IDLE cycle: the write is part of the frame
    start_run(1'b1, 1'b1, 4'd0, 16'h0777);
    wait_result(NOMINAL_LAT);

    // Spurious DONE during FEED is ignored
    spurious = 1'b1;
    start_run(1'b1, 1'b0, '0, '0);
    wait_result(NOMINAL_LAT);
    spurious = 1'b0;

    // Async reset during FEED at sample 7
    start_run(1'b1, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_fft_start", {31'd0, fft_start}, 32'd0);
    check("midreset_fft_din", {16'd0, fft_din}, 32'd0);
    check("midreset_result_valid", {31'd0, result_valid}, 32'd0);
    check("midreset_err", {31'd0, err}, 32'd0);
    exp_din_q.delete();
    exp_res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_frame(16'h0100, 16'h0011);
    start_run(1'b1, 1'b0, '0, '0);
    wait_result(NOMINAL_LAT);

`ifdef FFT_STREAM_DRIVER_TIMEOUT_EN
    // Core never answers: 64 WAIT cycles then ERR, BUSY low, no RESULT_VALID
    begin
      int lat;
      no_done = 1'b1;
      start_run(1'b0, 1'b0, '0, '0);
      lat = 1;
      while (busy && lat < 400) begin
        @(negedge clk);
        lat++;
      end
      check("timeout_latency", lat, 32'd82);
      check("timeout_err", {31'd0, err}, 32'd1);
      check("timeout_result_valid", {31'd0, result_valid}, 32'd0);
      no_done = 1'b0;
      repeat (3) @(negedge clk);
      check("err_sticky", {31'd0, err}, 32'd1);
      start_run(1'b1, 1'b0, '0, '0);
      wait_result(NOMINAL_LAT);
    end
`else
    check("err_tied_low", {31'd0, err}, 32'd0);
`endif

    // START_TO_DATA = 3 instance: two zero cycles between start and sample 0
    for (int k = 0; k < N; k++) begin
      wr_en3 = 1'b1; wr_addr = AW'(k); wr_data = 16'hA000 + DW'(k);
      @(negedge clk);
    end
    wr_en3 = 1'b0;
    go3 = 1'b1;
    @(negedge clk);
    go3 = 1'b0;
    check("s2d_start_high", {31'd0, start3}, 32'd1);
    check("s2d_din_at_start", {16'd0, din3}, 32'd0);
    @(negedge clk);
    check("s2d_start_low", {31'd0, start3}, 32'd0);
    check("s2d_lead0", {16'd0, din3}, 32'd0);
    @(negedge clk);
    check("s2d_lead1", {16'd0, din3}, 32'd0);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      check($sformatf("s2d_din[%0d]", k), {16'd0, din3}, 32'hA000 + k);
    end
    @(negedge clk);
    check("s2d_din_after", {16'd0, din3}, 32'd0);
    done3 = 1'b1; dout3 = 16'h1230;
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      done3 = 1'b0; dout3 = 16'h1230 + DW'(i);
    end
    @(negedge clk);
    dout3 = '0;
    check("s2d_result_valid", {31'd0, rv3}, 32'd1);
    check("s2d_busy_low", {31'd0, busy3}, 32'd0);
    rd_addr3 = 4'd0;  #1;
    check("s2d_result[0]", {16'd0, rd_data3}, 32'h1230);
    rd_addr3 = 4'd15; #1;
    check("s2d_result[15]", {16'd0, rd_data3}, 32'h123F);

    repeat (3) @(negedge clk);
    check("din_queue_drained", exp_din_q.size(), 32'd0);
    check("res_queue_drained", exp_res_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
